// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-interlock types: FSM state, register-zero sentinel, NOP encoding
// and the register-hit helper used by the hazard compares.
package hazard_stall_unit_pkg;

  typedef enum logic {RUN = 1'b0, MISS_WAIT = 1'b1} state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> interlock bundle: ID/EX/MEM operand info and cache-miss levels in,
// stage enables, flushes and perf counters out.
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
  logic [4:0]       ID_Rs, ID_Rt;
  logic             ID_UsesRt, ID_Branch;
  logic             EX_MemRead, EX_RegWrite;
  logic [4:0]       EX_WR_out;
  logic             M_MemRead;
  logic [4:0]       M_WR_out;
  logic             BranchTaken, IC_stall, DC_stall;
  logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic             EX_M_Write, M_WB_Write, miss_timeout;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, EX_MemRead, EX_RegWrite, EX_WR_out,
           M_MemRead, M_WR_out, BranchTaken, IC_stall, DC_stall,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_M_Write, M_WB_Write,
           miss_timeout, stall_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, EX_MemRead, EX_RegWrite, EX_WR_out,
           M_MemRead, M_WR_out, BranchTaken, IC_stall, DC_stall,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_M_Write, M_WB_Write,
           miss_timeout, stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/hazard_stall_unit.sv
// Producer-side interlock: freezes on L1 misses, bubbles on load-use / ID-branch
// operand hazards, flushes IF/ID on taken branches (deferred across a freeze).
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MISS_TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_unit_if.slave hs
);
  localparam int                WAIT_W   = $clog2(MISS_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MISS_TIMEOUT);

  state_e            state;
  logic              pend_flush, timeout_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu, br, hz, miss, flush_req;
  logic              stall_inc, bubble_inc, flush_inc;

  assign lu = hs.EX_MemRead && reg_hit(hs.EX_WR_out, hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt);
  assign br = hs.ID_Branch &&
              ((hs.EX_RegWrite && reg_hit(hs.EX_WR_out, hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt)) ||
               (hs.M_MemRead   && reg_hit(hs.M_WR_out,  hs.ID_Rs, hs.ID_Rt, hs.ID_UsesRt)));
  assign hz        = lu || br;
  assign miss      = hs.IC_stall || hs.DC_stall;
  assign flush_req = hs.BranchTaken || pend_flush;

  assign stall_inc  = (state == MISS_WAIT) && miss;
  assign bubble_inc = !miss && hz;
  assign flush_inc  = !miss && !hz && flush_req;

  // Priority miss > hazard > flush; the release cycle of a miss is plain RUN logic.
  always_comb begin
    hs.PCWrite     = 1'b1;
    hs.IF_ID_Write = 1'b1;
    hs.EX_M_Write  = 1'b1;
    hs.M_WB_Write  = 1'b1;
    hs.IF_ID_Flush = 1'b0;
    hs.ID_EX_Flush = 1'b0;
    if (rst_n) begin
      if (miss) begin
        hs.PCWrite     = 1'b0;
        hs.IF_ID_Write = 1'b0;
        hs.EX_M_Write  = 1'b0;
        hs.M_WB_Write  = 1'b0;
      end else if (hz) begin
        hs.PCWrite     = 1'b0;
        hs.IF_ID_Write = 1'b0;
        hs.ID_EX_Flush = 1'b1;
      end else if (flush_req) begin
        hs.IF_ID_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (flush_inc) pend_flush <= 1'b0;
      case (state)
        RUN:
          if (miss) begin
            state <= MISS_WAIT;
            // A branch resolved on the freeze edge must still redirect fetch later.
            if (hs.BranchTaken && !hz) pend_flush <= 1'b1;
          end
        MISS_WAIT:
          if (miss) begin
            if (wait_cnt != WAIT_MAX) wait_cnt  <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_MAX) timeout_q <= 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
      endcase
    end

  assign hs.miss_timeout = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_inc), .cnt(hs.stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .inc(bubble_inc), .cnt(hs.bubble_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_inc), .cnt(hs.flush_cnt));

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: each driven cycle pushes the expected control vector,
// a negedge monitor pops and compares; counters checked at scenario ends.
module tb_hazard_stall_unit;
  // ctrl = {PCWrite, IF_ID_Write, EX_M_Write, M_WB_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [5:0] C_RUN = 6'b111100;
  localparam logic [5:0] C_BUB = 6'b001101;
  localparam logic [5:0] C_FLU = 6'b111110;
  localparam logic [5:0] C_FRZ = 6'b000000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(32)) bus ();
  hazard_stall_unit #(.CNT_W(32), .MISS_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .hs(bus));

  wire [5:0] ctrl = {bus.PCWrite, bus.IF_ID_Write, bus.EX_M_Write, bus.M_WB_Write,
                     bus.IF_ID_Flush, bus.ID_EX_Flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (exp_q.size() != 0) chk("ctrl", 32'(ctrl), 32'(exp_q.pop_front()));

  task automatic idle();
    bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0; bus.ID_UsesRt = 1'b0; bus.ID_Branch = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WR_out = 5'd0;
    bus.M_MemRead = 1'b0; bus.M_WR_out = 5'd0;
    bus.BranchTaken = 1'b0; bus.IC_stall = 1'b0; bus.DC_stall = 1'b0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WR_out = rd;
  endtask

  // One clock with current inputs; expected control queued for the monitor.
  task automatic cyc(input logic [5:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    bus.DC_stall = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_bubble", bus.bubble_cnt, 0);
    chk("rst_flush", bus.flush_cnt, 0);
    chk("rst_tmo", 32'(bus.miss_timeout), 0);
    idle();
    rst_n = 1'b1;
    cyc(C_RUN);

    // load-use: lw $8 in EX, add $9,$8,$1 in ID
    ex_load(5'd8); bus.ID_Rs = 5'd8; bus.ID_Rt = 5'd1; bus.ID_UsesRt = 1'b1;
    cyc(C_BUB);
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WR_out = 5'd0;
    cyc(C_RUN);
    chk("lu_bubble", bus.bubble_cnt, 1);
    // Rt only counts when the instruction reads it
    ex_load(5'd8); bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd8; bus.ID_UsesRt = 1'b0;
    cyc(C_RUN);
    bus.ID_UsesRt = 1'b1;
    cyc(C_BUB);
    chk("lu_rt_bubble", bus.bubble_cnt, 2);

    // load -> beq $8: EX term then MEM term
    idle(); ex_load(5'd8);
    bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd8; bus.ID_Rt = 5'd2; bus.ID_UsesRt = 1'b1;
    cyc(C_BUB);
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WR_out = 5'd0;
    bus.M_MemRead = 1'b1; bus.M_WR_out = 5'd8;
    cyc(C_BUB);
    bus.M_MemRead = 1'b0; bus.M_WR_out = 5'd0;
    cyc(C_RUN);
    chk("br_bubble", bus.bubble_cnt, 4);
    // dest $0 never matches
    ex_load(5'd0); bus.ID_Rs = 5'd0;
    cyc(C_RUN);
    // ALU result feeding branch, taken branch ignored while bubbling
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b1; bus.EX_WR_out = 5'd2;
    bus.BranchTaken = 1'b1;
    cyc(C_BUB);
    chk("br_alu_bubble", bus.bubble_cnt, 5);
    chk("br_hz_noflush", bus.flush_cnt, 0);

    // plain taken branch
    idle(); bus.BranchTaken = 1'b1;
    cyc(C_FLU);
    idle();
    cyc(C_RUN);
    chk("flush_cnt1", bus.flush_cnt, 1);

    // D-cache miss: entry + 5 waiting cycles
    bus.DC_stall = 1'b1;
    for (int i = 0; i < 6; i++) cyc(C_FRZ);
    bus.DC_stall = 1'b0;
    cyc(C_RUN);
    chk("dc_stall_cnt", bus.stall_cnt, 5);

    // taken branch on I-miss edge: flush deferred to release
    bus.IC_stall = 1'b1; bus.BranchTaken = 1'b1;
    cyc(C_FRZ);
    bus.BranchTaken = 1'b0;
    cyc(C_FRZ); cyc(C_FRZ);
    bus.IC_stall = 1'b0;
    cyc(C_FLU);
    cyc(C_RUN);
    chk("def_flush_cnt", bus.flush_cnt, 2);
    chk("def_stall_cnt", bus.stall_cnt, 7);

    // miss beats load-use; hazard re-evaluated on release
    ex_load(5'd8); bus.ID_Rs = 5'd8; bus.DC_stall = 1'b1;
    cyc(C_FRZ);
    bus.DC_stall = 1'b0;
    cyc(C_BUB);
    idle();
    cyc(C_RUN);
    chk("miss_hz_bubble", bus.bubble_cnt, 6);

    // long miss: sticky timeout
    bus.DC_stall = 1'b1;
    for (int i = 0; i < 200; i++) cyc(C_FRZ);
    chk("tmo_early", 32'(bus.miss_timeout), 0);
    for (int i = 0; i < 100; i++) cyc(C_FRZ);
    chk("tmo_set", 32'(bus.miss_timeout), 1);
    chk("tmo_stall_cnt", bus.stall_cnt, 306);
    bus.DC_stall = 1'b0;
    cyc(C_RUN);
    chk("tmo_sticky", 32'(bus.miss_timeout), 1);

    // async reset mid-miss drops pending flush
    bus.IC_stall = 1'b1; bus.BranchTaken = 1'b1;
    cyc(C_FRZ);
    bus.BranchTaken = 1'b0;
    cyc(C_FRZ);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("amid_stall", bus.stall_cnt, 0);
    chk("amid_bubble", bus.bubble_cnt, 0);
    chk("amid_flush", bus.flush_cnt, 0);
    chk("amid_tmo", 32'(bus.miss_timeout), 0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    cyc(C_RUN);
    cyc(C_RUN);
    chk("post_rst_flush", bus.flush_cnt, 0);
    chk("post_rst_stall", bus.stall_cnt, 0);

    @(negedge clk); #1;
    chk("q_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
